// File: rtl/alu_pipe_pkg.sv
// Shared types for the handshaked accumulator ALU: opcode encoding and flag bundle.
package alu_pipe_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 4'h0,
    OP_SKZ = 4'h1,
    OP_ADD = 4'h2,
    OP_AND = 4'h3,
    OP_XOR = 4'h4,
    OP_LDA = 4'h5,
    OP_STO = 4'h6,
    OP_JMP = 4'h7,
    OP_SUB = 4'h8,
    OP_OR  = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_MUL = 4'hC
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  // Control-flow style opcodes simply pass the accumulator through.
  function automatic logic op_is_pass(alu_op_t op);
    return (op == OP_HLT) || (op == OP_SKZ) || (op == OP_STO) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/alu_pipe_mul_shift_add.sv
// Sequential unsigned multiplier: one partial-product step per cycle, WIDTH steps,
// full 2*WIDTH product. done pulses for one cycle once the product is final.
module mul_shift_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  assign product = acc;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        count  <= CW'(WIDTH - 1);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (count == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked accumulator ALU: single-cycle ops complete with latency 1,
// MUL runs through the shift-add sub-block. Result and flags are held until taken.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             state;
  alu_flags_t         flags;

  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  alu_flags_t         res_flags;

  assign sh        = data[SHW-1:0];
  assign in_ready  = !rst && (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (MUL_EN != 0) && (opcode == OP_MUL);
  assign mul_start = accept && is_mul;

  assign zero      = flags.zero;
  assign negative  = flags.negative;
  assign carry     = flags.carry;
  assign overflow  = flags.overflow;
  assign busy      = mul_busy;

  // Single-cycle datapath; the shifts use one extra bit to catch the last bit shifted out.
  always_comb begin
    add_ext = {1'b0, accum} + {1'b0, data};
    sub_ext = {1'b0, accum} - {1'b0, data};
    shl_ext = {1'b0, accum} << sh;
    shr_ext = {accum, 1'b0} >> sh;
    res     = op_is_pass(opcode) ? accum : '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    case (opcode)
      OP_LDA: res = data;
      OP_AND: res = accum & data;
      OP_OR:  res = accum | data;
      OP_XOR: res = accum ^ data;
      OP_ADD: begin
        res   = add_ext[WIDTH-1:0];
        res_c = add_ext[WIDTH];
        res_v = (accum[MSB] == data[MSB]) && (res[MSB] != accum[MSB]);
      end
      OP_SUB: begin
        res   = sub_ext[WIDTH-1:0];
        res_c = sub_ext[WIDTH];
        res_v = (accum[MSB] != data[MSB]) && (res[MSB] != accum[MSB]);
      end
      OP_SHL: begin
        res   = shl_ext[WIDTH-1:0];
        res_c = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res   = shr_ext[WIDTH:1];
        res_c = shr_ext[0];
      end
      default: ;
    endcase
    res_flags.zero     = (res == '0);
    res_flags.negative = res[MSB];
    res_flags.carry    = res_c;
    res_flags.overflow = res_v;
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= S_MUL;
            end else begin
              out       <= res;
              flags     <= res_flags;
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            out            <= mul_product[WIDTH-1:0];
            flags.zero     <= (mul_product[WIDTH-1:0] == '0);
            flags.negative <= mul_product[MSB];
            flags.carry    <= 1'b0;
            flags.overflow <= |mul_product[2*WIDTH-1:WIDTH];
            out_valid      <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  if (MUL_EN != 0) begin : g_mul
    mul_shift_add #(
      .WIDTH(WIDTH)
    ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .a      (accum),
      .b      (data),
      .busy   (mul_busy),
      .done   (mul_done),
      .product(mul_product)
    );
  end else begin : g_no_mul
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): driver pushes model results, monitor pops on output handshake.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  alu_op_t    opcode;
  logic [7:0] accum;
  logic [7:0] data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       zero, negative, carry, overflow, busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .accum(accum), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model written from the opcode rules using integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t m;
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sbv = $signed(b);
    int sh = ub % 8;
    int r = 0;
    int c = 0;
    int v = 0;
    case (op)
      4'h0, 4'h1, 4'h6, 4'h7: r = ua;
      4'h5: r = ub;
      4'h3: r = ua & ub;
      4'h4: r = ua ^ ub;
      4'h9: r = ua | ub;
      4'h2: begin
        r = ua + ub;
        c = (r > 255) ? 1 : 0;
        v = ((sa + sbv) > 127 || (sa + sbv) < -128) ? 1 : 0;
      end
      4'h8: begin
        r = ua - ub;
        c = (ua < ub) ? 1 : 0;
        v = ((sa - sbv) > 127 || (sa - sbv) < -128) ? 1 : 0;
      end
      4'hA: begin
        r = ua << sh;
        c = (sh != 0) ? ((ua >> (8 - sh)) & 1) : 0;
      end
      4'hB: begin
        r = ua >> sh;
        c = (sh != 0) ? ((ua >> (sh - 1)) & 1) : 0;
      end
      4'hC: begin
        r = ua * ub;
        v = (r > 255) ? 1 : 0;
      end
      default: r = 0;
    endcase
    m.res = 8'(r & 255);
    m.z   = (m.res == 8'h00);
    m.n   = m.res[7];
    m.c   = c[0];
    m.v   = v[0];
    return m;
  endfunction

  // Present an op, wait (bounded) for acceptance, push its expected result.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int acc_cyc);
    bit ok = 0;
    opcode   = alu_op_t'(op);
    accum    = a;
    data     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      acc_cyc  = cyc;
      return;
    end
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every transferred result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {24'd0, out}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("result", {23'd0, out, zero, negative, carry, overflow},
                {23'd0, e.res, e.z, e.n, e.c, e.v});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, r, prev, bc, first;
    logic [7:0] held, at_valid;
    logic [3:0] op;
    bit rand_done;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = OP_HLT; accum = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {23'd0, out, zero, negative, carry, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with carry, latency 1
    send(4'h2, 8'hF0, 8'h20, n);
    check("add_valid_lat1", {31'd0, out_valid}, 32'd1);
    check("add_out", {24'd0, out}, 32'h10);
    check("add_flags", {28'd0, zero, negative, carry, overflow}, 32'b0010);

    send(4'h8, 8'h05, 8'h05, n);
    check("sub_eq", {23'd0, out, zero, carry}, {23'd0, 8'h00, 1'b1, 1'b0});
    send(4'h8, 8'h80, 8'h01, n);
    check("sub_ovf", {22'd0, out, overflow, carry}, {22'd0, 8'h7F, 1'b1, 1'b0});

    send(4'hA, 8'h81, 8'h01, n);
    check("shl", {23'd0, out, carry}, {23'd0, 8'h02, 1'b1});
    send(4'hB, 8'h01, 8'h00, n);
    check("shr0", {23'd0, out, carry}, {23'd0, 8'h01, 1'b0});
    send(4'hF, 8'h5A, 8'hA5, n);
    check("unknown", {23'd0, out, zero}, {23'd0, 8'h00, 1'b1});

    // MUL: busy duration and latency
    send(4'hC, 8'h0D, 8'h0B, n);
    bc = 0; first = -1; at_valid = '0;
    while (cyc - n <= 11) begin
      @(negedge clk);
      if (busy) bc++;
      if (out_valid && first < 0) begin
        first    = cyc - n;
        at_valid = out;
      end
    end
    check("mul_busy_cycles", bc, 32'd8);
    check("mul_latency", first, 32'd9);
    check("mul_out", {24'd0, at_valid}, 32'h8F);
    @(posedge clk); #1;

    send(4'hC, 8'h10, 8'h10, n);
    for (int i = 0; i < 15 && !out_valid; i++) @(posedge clk);
    #1;
    check("mul_trunc", {23'd0, out, zero, overflow}, {23'd0, 8'h00, 1'b1, 1'b1});
    @(posedge clk); #1;

    // Backpressure: hold result 5 cycles, then drain and accept on the same edge
    out_ready = 1'b0;
    send(4'h2, 8'h33, 8'h44, n);
    held = out;
    check("stall_value", {24'd0, held}, 32'h77);
    opcode = OP_XOR; accum = 8'h0F; data = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {22'd0, out, out_valid, in_ready}, {22'd0, held, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    r = cyc;
    send(4'h4, 8'h0F, 8'hFF, m);
    check("release_accept", m - r, 32'd1);
    @(posedge clk); #1;

    // Reset during MUL step 4 aborts it
    send(4'hC, 8'hFF, 8'hFF, n);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb.pop_back());
    check("rst_in_ready_mid", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_outputs", {21'd0, out, zero, negative, carry, overflow, out_valid, busy}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    send(4'h2, 8'h01, 8'h02, n);
    check("post_rst_add", {23'd0, out, out_valid}, {23'd0, 8'h03, 1'b1});

    // Back-to-back single-cycle ops
    prev = n;
    for (int i = 0; i < 10; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hC) op = 4'h9;
      send(op, 8'($urandom), 8'($urandom), m);
      check("b2b_accept", m - prev, 32'd1);
      prev = m;
    end

    // Random ops including MUL under random backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), m);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    in_valid  = 1'b0;

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
